// File: rtl/regfile_alu_pkg.sv
// Shared constants for the register-file / ALU datapath core:
// datapath geometry and the 4-bit opcode encodings (instruction[15:12]).
package regfile_alu_pkg;

  localparam int DATA_W   = 16;
  localparam int NREGS    = 8;
  localparam int ADDR_W   = $clog2(NREGS);
  localparam int OPCODE_W = 4;
  localparam int SHAMT_W  = $clog2(DATA_W);

  localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_ADDI = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0010;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0011;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'b0100;
  localparam logic [OPCODE_W-1:0] OP_OR   = 4'b0101;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 4'b0110;
  localparam logic [OPCODE_W-1:0] OP_SLL  = 4'b0111;
  localparam logic [OPCODE_W-1:0] OP_SRL  = 4'b1000;
  localparam logic [OPCODE_W-1:0] OP_SLT  = 4'b1001;
  localparam logic [OPCODE_W-1:0] OP_OUT  = 4'b1111;

endpackage : regfile_alu_pkg

// File: rtl/regfile_alu_core_if.sv
// Bus between the decode/sequencing logic (master) and the datapath core
// (slave): opcode, register addresses and write strobe/data go down,
// read-port values and the ALU result come back combinationally.
interface regfile_alu_core_if;
  import regfile_alu_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic [ADDR_W-1:0]   address_a;
  logic [ADDR_W-1:0]   address_b;
  logic                write_enable;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W-1:0]   data_a;
  logic [DATA_W-1:0]   data_b;
  logic [DATA_W-1:0]   alu_result;
  logic                zero;

  modport master (
    output opcode, address_a, address_b, write_enable, write_data,
    input  data_a, data_b, alu_result, zero
  );

  modport slave (
    input  opcode, address_a, address_b, write_enable, write_data,
    output data_a, data_b, alu_result, zero
  );

endinterface : regfile_alu_core_if

// File: rtl/regfile_8x16.sv
// 8 x 16-bit register file: one synchronous write port, two asynchronous
// read ports. A read of the address being written returns the old value
// until the clock edge commits the write.
module regfile_8x16
  import regfile_alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_address,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_address_a,
  input  logic [ADDR_W-1:0] read_address_b,
  output logic [DATA_W-1:0] read_data_a,
  output logic [DATA_W-1:0] read_data_b
);

  logic [DATA_W-1:0] regs [NREGS];

  // Storage update: synchronous clear has priority over the write strobe.
  // NOTE: the array is reset on purpose -- software relies on every
  // register reading zero after reset, so this stays flops rather than RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        // NOTE: state is always assigned with <= so every reader sees the
        // pre-edge value, which is what gives read-during-write its old data.
        regs[i] <= '0;
      end
    end else if (write_enable) begin
      regs[write_address] <= write_data;
    end
  end

  assign read_data_a = regs[read_address_a];
  assign read_data_b = regs[read_address_b];

endmodule : regfile_8x16

// File: rtl/regfile_alu_core.sv
// 16-bit datapath core: register file plus a combinational ALU that always
// operates on the two read-port values. Write-back source selection
// (ALU result vs immediate) lives in the caller; since the write is
// registered, feeding alu_result back into write_data forms no loop.
module regfile_alu_core
  import regfile_alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  regfile_alu_core_if.slave  bus
);

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] result;

  regfile_8x16 u_regfile (
    .clk            (clk),
    .reset          (reset),
    .write_enable   (bus.write_enable),
    .write_address  (bus.address_a),
    .write_data     (bus.write_data),
    .read_address_a (bus.address_a),
    .read_address_b (bus.address_b),
    .read_data_a    (a),
    .read_data_b    (b)
  );

  // ALU operation select; non-arithmetic opcodes produce zero.
  always_comb begin
    // NOTE: default first so every path assigns result and no latch forms.
    result = '0;
    case (bus.opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLL:  result = a << b[SHAMT_W-1:0];
      OP_SRL:  result = a >> b[SHAMT_W-1:0];
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  assign bus.data_a     = a;
  assign bus.data_b     = b;
  assign bus.alu_result = result;
  assign bus.zero       = (result == '0);

endmodule : regfile_alu_core

// File: tb/tb_regfile_alu_core.sv
// Directed bench for regfile_alu_core. Stimulus drives one vector per
// cycle just after the rising edge and pushes the hand-computed response
// into a scoreboard queue; a monitor pops and compares on the falling edge.
module tb_regfile_alu_core;
  import regfile_alu_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] da;
    logic [15:0] db;
    logic [15:0] res;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  regfile_alu_core_if bus ();

  regfile_alu_core u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
    end
  endtask

  // Drive one vector for one cycle, right after the rising edge.
  task automatic drive(input logic rst, input logic [3:0] op, input logic [2:0] aa,
                       input logic [2:0] ab, input logic we, input logic [15:0] wd);
    @(posedge clk);
    #1;
    reset            = rst;
    bus.opcode       = op;
    bus.address_a    = aa;
    bus.address_b    = ab;
    bus.write_enable = we;
    bus.write_data   = wd;
  endtask

  task automatic expect_out(input string name, input logic [15:0] da, input logic [15:0] db,
                            input logic [15:0] res, input logic z);
    exp_t e;
    e.name = name; e.da = da; e.db = db; e.res = res; e.z = z;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [2:0] r, input logic [15:0] v);
    drive(1'b0, OP_NOP, r, 3'd0, 1'b1, v);
  endtask

  // Monitor: compare every pending expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".data_a"},     bus.data_a,     e.da);
        check({e.name, ".data_b"},     bus.data_b,     e.db);
        check({e.name, ".alu_result"}, bus.alu_result, e.res);
        check({e.name, ".zero"},       {15'd0, bus.zero}, {15'd0, e.z});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] odd_ops [5];
    odd_ops[0] = OP_ADDI; odd_ops[1] = OP_OUT; odd_ops[2] = 4'b1100;
    odd_ops[3] = OP_NOP;  odd_ops[4] = 4'b1010;

    bus.opcode = OP_NOP; bus.address_a = '0; bus.address_b = '0;
    bus.write_enable = 1'b0; bus.write_data = '0;

    // Initial reset, then fill every register with all-ones.
    drive(1'b1, OP_NOP, 3'd0, 3'd0, 1'b0, 16'h0000);
    for (int i = 0; i < NREGS; i++) wr(3'(i), 16'hFFFF);
    // Reset cycle: contents still all-ones before the edge.
    drive(1'b1, OP_ADD, 3'd7, 3'd0, 1'b0, 16'h0000);
    expect_out("pre_reset_add", 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0);
    for (int i = 0; i < NREGS; i++) begin
      drive(1'b0, OP_ADD, 3'(i), 3'(7 - i), 1'b0, 16'h0000);
      expect_out($sformatf("post_reset_r%0d", i), 16'h0000, 16'h0000, 16'h0000, 1'b1);
    end
    // Reset wins over write_enable.
    drive(1'b1, OP_NOP, 3'd0, 3'd0, 1'b1, 16'hABCD);
    drive(1'b0, OP_OR, 3'd0, 3'd0, 1'b0, 16'h0000);
    expect_out("reset_beats_write", 16'h0000, 16'h0000, 16'h0000, 1'b1);

    // Basic write / read / ADD.
    wr(3'd1, 16'h0005);
    wr(3'd2, 16'h0007);
    drive(1'b0, OP_ADD, 3'd1, 3'd2, 1'b0, 16'h0000);
    expect_out("add_5_7", 16'h0005, 16'h0007, 16'h000C, 1'b0);

    // Read-during-write: old value before the edge, new after.
    wr(3'd3, 16'h1111);
    drive(1'b0, OP_ADD, 3'd3, 3'd3, 1'b1, 16'h2222);
    expect_out("rdw_before", 16'h1111, 16'h1111, 16'h2222, 1'b0);
    drive(1'b0, OP_XOR, 3'd3, 3'd3, 1'b0, 16'h0000);
    expect_out("rdw_after", 16'h2222, 16'h2222, 16'h0000, 1'b1);

    // Wrap-around arithmetic and signed compare.
    wr(3'd4, 16'hFFFF);
    wr(3'd5, 16'h0001);
    drive(1'b0, OP_ADD, 3'd4, 3'd5, 1'b0, 16'h0000);
    expect_out("add_wrap", 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    drive(1'b0, OP_SUB, 3'd5, 3'd4, 1'b0, 16'h0000);
    expect_out("sub_wrap", 16'h0001, 16'hFFFF, 16'h0002, 1'b0);
    drive(1'b0, OP_SLT, 3'd4, 3'd5, 1'b0, 16'h0000);
    expect_out("slt_neg_lt_pos", 16'hFFFF, 16'h0001, 16'h0001, 1'b0);
    drive(1'b0, OP_SLT, 3'd5, 3'd4, 1'b0, 16'h0000);
    expect_out("slt_pos_ge_neg", 16'h0001, 16'hFFFF, 16'h0000, 1'b1);
    drive(1'b0, OP_SLL, 3'd5, 3'd4, 1'b0, 16'h0000);
    expect_out("sll_by_15", 16'h0001, 16'hFFFF, 16'h8000, 1'b0);
    drive(1'b0, OP_SRL, 3'd4, 3'd5, 1'b0, 16'h0000);
    expect_out("srl_by_1", 16'hFFFF, 16'h0001, 16'h7FFF, 1'b0);

    // Logic and shifts.
    wr(3'd6, 16'h00F0);
    wr(3'd7, 16'h0004);
    drive(1'b0, OP_AND, 3'd6, 3'd7, 1'b0, 16'h0000);
    expect_out("and", 16'h00F0, 16'h0004, 16'h0000, 1'b1);
    drive(1'b0, OP_OR, 3'd6, 3'd7, 1'b0, 16'h0000);
    expect_out("or", 16'h00F0, 16'h0004, 16'h00F4, 1'b0);
    drive(1'b0, OP_XOR, 3'd6, 3'd7, 1'b0, 16'h0000);
    expect_out("xor", 16'h00F0, 16'h0004, 16'h00F4, 1'b0);
    drive(1'b0, OP_SLL, 3'd6, 3'd7, 1'b0, 16'h0000);
    expect_out("sll", 16'h00F0, 16'h0004, 16'h0F00, 1'b0);
    drive(1'b0, OP_SRL, 3'd6, 3'd7, 1'b0, 16'h0000);
    expect_out("srl", 16'h00F0, 16'h0004, 16'h000F, 1'b0);
    drive(1'b0, OP_SUB, 3'd6, 3'd7, 1'b0, 16'h0000);
    expect_out("sub", 16'h00F0, 16'h0004, 16'h00EC, 1'b0);

    // Non-ALU opcodes yield zero; write_enable low leaves contents alone.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, odd_ops[i], 3'd6, 3'd7, 1'b0, 16'hDEAD);
      expect_out($sformatf("non_alu_op_%b", odd_ops[i]), 16'h00F0, 16'h0004, 16'h0000, 1'b1);
    end
    drive(1'b0, OP_ADD, 3'd6, 3'd7, 1'b0, 16'h0000);
    expect_out("regs_unchanged", 16'h00F0, 16'h0004, 16'h00F4, 1'b0);

    // Let the monitor drain the scoreboard within a bounded time.
    for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_alu_core
